// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter slice.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;
    localparam int unsigned GRANT_W     = 3;
    localparam int unsigned MAX_REQ     = 8;
    localparam int unsigned STATE_W     = 3;

    localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
    localparam logic [STATE_W-1:0] ST_LAUNCH      = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_ACTIVE = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_DONE   = 3'd3;
    localparam logic [STATE_W-1:0] ST_RELEASE     = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] winner,
    output logic               any
);

    logic [MAX_REQ-1:0] req_pad;
    logic [GRANT_W:0]   idx_sum;
    logic [GRANT_W-1:0] idx;
    logic               found;

    assign req_pad = MAX_REQ'(req);
    assign any     = |req;

    // Scan ptr, ptr+1, ... modulo NUM_REQ and keep the first hit.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx_sum = '0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx_sum = {1'b0, ptr} + (GRANT_W+1)'(i);
            if (idx_sum >= (GRANT_W+1)'(NUM_REQ)) begin
                idx_sum = idx_sum - (GRANT_W+1)'(NUM_REQ);
            end
            idx = idx_sum[GRANT_W-1:0];
            if (!found && req_pad[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX serializer between NUM_REQ byte producers.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned TIMEOUT_CLKS = 16
) (
    input  logic                           i_Clock,
    input  logic                           i_Rst_n,
    input  logic [NUM_REQ-1:0]             i_Req,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]             o_Ack,
    output logic [NUM_REQ-1:0]             o_Done,
    output logic [GRANT_W-1:0]             o_Grant_Id,
    output logic                           o_Busy,
    output logic                           o_Err,
    output logic                           o_TX_DV,
    output logic [UART_BYTE_W-1:0]         o_TX_Byte,
    input  logic                           i_TX_Active,
    input  logic                           i_TX_Done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);

    logic [STATE_W-1:0]     state_q, state_d;
    logic [GRANT_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_REQ-1:0]     ack_d, done_d;
    logic [GRANT_W-1:0]     grant_d;
    logic                   busy_d, err_d, dv_d;
    logic [UART_BYTE_W-1:0] byte_d;

    logic [GRANT_W-1:0]     winner_c;
    logic                   any_c;
    logic [GRANT_W-1:0]     next_ptr_c;
    logic [UART_BYTE_W-1:0] req_bytes [MAX_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (i_Req),
        .ptr    (ptr_q),
        .winner (winner_c),
        .any    (any_c)
    );

    // Unpack the byte bus into a fixed-depth table so the winner index selects directly.
    for (genvar g = 0; g < MAX_REQ; g++) begin : g_bytes
        if (g < NUM_REQ) begin : g_used
            assign req_bytes[g] = i_Req_Byte[g*UART_BYTE_W +: UART_BYTE_W];
        end else begin : g_pad
            assign req_bytes[g] = '0;
        end
    end

    assign next_ptr_c = (o_Grant_Id == GRANT_W'(NUM_REQ - 1)) ? '0
                                                              : o_Grant_Id + GRANT_W'(1);

    // Next-state and next-output logic; everything registered below.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        dv_d    = 1'b0;
        busy_d  = o_Busy;
        grant_d = o_Grant_Id;
        byte_d  = o_TX_Byte;
        case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    byte_d  = req_bytes[winner_c];
                    grant_d = winner_c;
                    ack_d   = NUM_REQ'(1) << winner_c;
                    busy_d  = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                dv_d    = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_ACTIVE;
            end
            ST_WAIT_ACTIVE: begin
                if (i_TX_Active) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
                    // Serializer never started: drop this byte and move on.
                    err_d   = 1'b1;
                    ptr_d   = next_ptr_c;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (i_TX_Done) begin
                    done_d  = NUM_REQ'(1) << o_Grant_Id;
                    ptr_d   = next_ptr_c;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Absorb the second cycle of i_TX_Done before re-arbitrating.
                if (!i_TX_Done && !i_TX_Active) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers with synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            o_Ack      <= '0;
            o_Done     <= '0;
            o_Grant_Id <= '0;
            o_Busy     <= 1'b0;
            o_Err      <= 1'b0;
            o_TX_DV    <= 1'b0;
            o_TX_Byte  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            o_Ack      <= ack_d;
            o_Done     <= done_d;
            o_Grant_Id <= grant_d;
            o_Busy     <= busy_d;
            o_Err      <= err_d;
            o_TX_DV    <= dv_d;
            o_TX_Byte  <= byte_d;
        end
    end

endmodule
